// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM responder: command opcodes and FSM state encoding.
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Byte-wide storage: asynchronous read, write on the rising clk edge when wr_en is high.
// Contents are deliberately not reset so data survives a controller reset.
module spi_ram_array #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [7:0]           wr_dat,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_dat
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/spi_ram_responder.sv
// SPI target fronting a byte RAM: 8-bit command, 24-bit address, then LSB-first data.
// Read data is combinational from the RAM, so the first bit appears in the slot after the last address bit.
module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_select,
    input  logic spi_clk_enable,
    input  logic spi_in,
    output logic spi_out
);

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    state_t                 state, state_nxt;
    logic                   slot;
    logic [7:0]             cmd_sr;
    logic [4:0]             bit_cnt;
    logic [ADDR_BITS-1:0]   addr;
    logic [2:0]             bit_idx;
    logic [6:0]             wr_sr;
    logic [7:0]             cmd_full;
    logic [ADDR_BITS-1:0]   addr_full;
    logic [7:0]             wr_byte;
    logic                   wr_en;
    logic [7:0]             rd_dat;

    assign slot      = !spi_select && spi_clk_enable;
    assign cmd_full  = {cmd_sr[6:0], spi_in};
    // Address bits shift straight into addr; bits above ADDR_BITS fall off the top.
    assign addr_full = {addr[ADDR_BITS-2:0], spi_in};
    assign wr_byte   = {spi_in, wr_sr};
    assign wr_en     = (state == WRITE) && slot && (bit_idx == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (spi_select) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = CMD;
                CMD: begin
                    if (slot && bit_cnt == 5'd7) begin
                        state_nxt = (cmd_full == CMD_READ || cmd_full == CMD_WRITE) ? ADDR : IGNORE;
                    end
                end
                ADDR: begin
                    if (slot && bit_cnt == 5'd23) begin
                        state_nxt = (cmd_sr == CMD_READ) ? READ : WRITE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_sr  <= '0;
            bit_cnt <= '0;
            addr    <= '0;
            bit_idx <= '0;
            wr_sr   <= '0;
        end else if (spi_select) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            wr_sr   <= '0;
        end else if (slot) begin
            case (state)
                IDLE: begin
                    cmd_sr  <= cmd_full;
                    bit_cnt <= 5'd1;
                end
                CMD: begin
                    cmd_sr  <= cmd_full;
                    bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
                end
                ADDR: begin
                    addr <= addr_full;
                    if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                READ: begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        addr <= addr + ADDR_ONE;
                    end
                end
                WRITE: begin
                    wr_sr   <= wr_byte[7:1];
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        addr <= addr + ADDR_ONE;
                    end
                end
                IGNORE: ;
                default: ;
            endcase
        end
    end

    spi_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (addr),
        .wr_dat  (wr_byte),
        .rd_addr (addr),
        .rd_dat  (rd_dat)
    );

    assign spi_out = (state == READ) ? rd_dat[bit_idx] : 1'b0;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomised SPI transactions checked against a byte-array model of the RAM.
module tb_spi_ram_responder;
    import spi_ram_pkg::*;

    localparam int ADDR_BITS = 8;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic clk = 1'b0;
    logic rst;
    logic spi_select;
    logic spi_clk_enable;
    logic spi_in;
    logic spi_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [DEPTH];

    always #5 clk = ~clk;

    spi_ram_responder #(
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_select     (spi_select),
        .spi_clk_enable (spi_clk_enable),
        .spi_in         (spi_in),
        .spi_out        (spi_out)
    );

    // One qualified bit slot; o is spi_out as seen by the initiator for this slot.
    task automatic xfer_bit(input logic b, output logic o);
        @(negedge clk);
        spi_select     = 1'b0;
        spi_clk_enable = 1'b1;
        spi_in         = b;
        o              = spi_out;
    endtask

    // Optional unqualified select edge before the first command bit.
    task automatic start_txn(input logic slow_start);
        if (slow_start) begin
            @(negedge clk);
            spi_select     = 1'b0;
            spi_clk_enable = 1'b0;
        end
    endtask

    task automatic end_txn();
        @(negedge clk);
        spi_clk_enable = 1'b0;
        spi_select     = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], o);
    endtask

    task automatic send_addr(input logic [23:0] a);
        logic o;
        for (int i = 23; i >= 0; i--) xfer_bit(a[i], o);
    endtask

    task automatic write_txn(input logic [23:0] a, input logic [7:0] d[$], input logic slow_start);
        logic o;
        start_txn(slow_start);
        send_byte(CMD_WRITE);
        send_addr(a);
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) xfer_bit(d[i][k], o);
            mem_model[(int'(a[ADDR_BITS-1:0]) + i) % DEPTH] = d[i];
        end
        end_txn();
    endtask

    task automatic read_txn(input logic [23:0] a, input int n, input logic slow_start,
                            output logic [7:0] got[$]);
        logic       o;
        logic [7:0] b;
        got = {};
        start_txn(slow_start);
        send_byte(CMD_READ);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                xfer_bit($urandom_range(0, 1), o);
                b[k] = o;
            end
            got.push_back(b);
        end
        end_txn();
    endtask

    task automatic test_reset();
        logic o;
        rst = 1'b1; spi_select = 1'b1; spi_clk_enable = 1'b0; spi_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (spi_out !== 1'b0) begin
            errors++; $display("FAIL reset_out got %b want 0", spi_out);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE);
        end
        // Bits presented while reset is held must not start anything.
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, o);
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || spi_out !== 1'b0) begin
            errors++; $display("FAIL reset_hold state %0d out %b want IDLE/0", dut.state, spi_out);
        end
        spi_select = 1'b1; spi_clk_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [7:0] d[$];
        logic [7:0] got[$];
        d = {8'hA5, 8'h3C};
        write_txn(24'h000010, d, 1'b1);
        read_txn(24'h000010, 2, 1'b0, got);
        checks++;
        if (got[0] !== 8'hA5) begin
            errors++; $display("FAIL rd_byte0 got %h want a5", got[0]);
        end
        checks++;
        if (got[1] !== 8'h3C) begin
            errors++; $display("FAIL rd_byte1 got %h want 3c", got[1]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d[$];
        logic [7:0] got[$];
        d = {8'h11, 8'h22};
        write_txn(24'h0000FF, d, 1'b0);
        read_txn(24'h1234FF, 2, 1'b1, got);
        checks++;
        if (got[0] !== 8'h11 || got[1] !== 8'h22) begin
            errors++; $display("FAIL wrap_read got %h %h want 11 22", got[0], got[1]);
        end
        read_txn(24'hABCD00, 1, 1'b0, got);
        checks++;
        if (got[0] !== 8'h22) begin
            errors++; $display("FAIL wrap_alias0 got %h want 22", got[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d[$];
        logic [7:0]  got[$];
        logic [23:0] a;
        int          n;
        int          idx;
        for (int t = 0; t < 8; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 5);
            d = {};
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            write_txn(a, d, 1'($urandom_range(0, 1)));
            read_txn(a, n, 1'($urandom_range(0, 1)), got);
            for (int i = 0; i < n; i++) begin
                idx = (int'(a[ADDR_BITS-1:0]) + i) % DEPTH;
                checks++;
                if (got[i] !== mem_model[idx]) begin
                    errors++;
                    $display("FAIL rand_read t%0d addr %h got %h want %h", t, idx, got[i], mem_model[idx]);
                end
            end
        end
    endtask

    task automatic test_gating();
        logic        o;
        logic        held;
        logic [15:0] want;
        int          bad_bits;
        int          bad_gaps;
        want     = {mem_model[8'h11], mem_model[8'h10]};
        bad_bits = 0;
        bad_gaps = 0;
        send_byte(CMD_READ);
        send_addr(24'h000010);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            spi_clk_enable = 1'b0;
            held = spi_out;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                if (spi_out !== held) bad_gaps++;
            end
            xfer_bit(1'b0, o);
            if (o !== want[k]) bad_bits++;
        end
        end_txn();
        checks++;
        if (bad_bits != 0) begin
            errors++; $display("FAIL gate_bits mismatched %0d want 0", bad_bits);
        end
        checks++;
        if (bad_gaps != 0) begin
            errors++; $display("FAIL gate_stable changes %0d want 0", bad_gaps);
        end
    endtask

    task automatic test_abort();
        logic [7:0] d[$];
        logic [7:0] got[$];
        logic       o;
        int         nonzero;
        d = {8'h5A};
        write_txn(24'h000020, d, 1'b0);
        nonzero = 0;
        send_byte(CMD_WRITE);
        send_addr(24'h000020);
        for (int k = 0; k < 5; k++) begin
            xfer_bit(1'($urandom_range(0, 1)), o);
            if (o !== 1'b0) nonzero++;
        end
        end_txn();
        send_byte(8'h9F);
        for (int k = 0; k < 40; k++) begin
            xfer_bit(1'($urandom_range(0, 1)), o);
            if (o !== 1'b0) nonzero++;
        end
        @(negedge clk);
        if (spi_out !== 1'b0) nonzero++;
        end_txn();
        checks++;
        if (nonzero != 0) begin
            errors++; $display("FAIL abort_out nonzero %0d want 0", nonzero);
        end
        read_txn(24'h000020, 1, 1'b1, got);
        checks++;
        if (got[0] !== mem_model[8'h20]) begin
            errors++; $display("FAIL abort_mem got %h want %h", got[0], mem_model[8'h20]);
        end
    endtask

    task automatic test_rst_mid();
        logic       o;
        logic [7:0] got[$];
        send_byte(CMD_READ);
        send_addr(24'h000011);
        for (int k = 0; k < 3; k++) xfer_bit(1'b0, o);
        @(negedge clk);
        spi_clk_enable = 1'b0;
        checks++;
        if (spi_out !== mem_model[8'h11][3]) begin
            errors++; $display("FAIL rst_pre_bit3 got %b want %b", spi_out, mem_model[8'h11][3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (spi_out !== 1'b0) begin
            errors++; $display("FAIL rst_mid_out got %b want 0", spi_out);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL rst_mid_state got %0d want %0d", dut.state, IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        end_txn();
        read_txn(24'h000010, 2, 1'b0, got);
        checks++;
        if (got[0] !== mem_model[8'h10] || got[1] !== mem_model[8'h11]) begin
            errors++;
            $display("FAIL rst_mem got %h %h want %h %h", got[0], got[1], mem_model[8'h10], mem_model[8'h11]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_gating();
        test_abort();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the number of implemented byte-address bits (memory depth 2^ADDR_BITS bytes).
REQ-002 SHALL have port clk  input  1  single system clock; all sampling is on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port spi_select  input  1  chip select, active-low.
REQ-005 SHALL have port spi_clk_enable  input  1  bit-slot qualifier; a bit is transferred only on edges where it is high.
REQ-006 SHALL have port spi_in  input  1  serial data from the initiator.
REQ-007 SHALL have port spi_out  output  1  serial data to the initiator.

Function
REQ-008 SHALL define one bit slot as a rising clk edge with spi_select low and spi_clk_enable high; edges with spi_clk_enable low SHALL change no state, and spi_out SHALL hold.
REQ-009 SHALL use states IDLE, CMD, ADDR, READ, WRITE and IGNORE.
REQ-010 SHALL move IDLE->CMD on any edge where spi_select is sampled low, consuming that edge's bit slot as command bit 7 if it qualifies.
REQ-011 SHALL shift 8 command bits MSB first, then 24 address bits MSB first.
REQ-012 SHALL on the 8th command bit go to ADDR for 0x03 (read) or 0x02 (write), else IGNORE.
REQ-013 SHALL on the 24th address bit load the address register with the low ADDR_BITS bits of the received address, clear the bit index, and go to READ or WRITE; upper address bits are ignored.
REQ-014 SHALL in READ drive spi_out combinationally as mem[addr][bit_idx], with data LSB first, so that bit 0 of the first byte is valid in the slot immediately after the final address bit (zero dummy cycles).
REQ-015 SHALL in READ advance bit_idx per bit slot; after bit 7, addr SHALL increment modulo 2^ADDR_BITS and bit_idx SHALL return to 0, streaming indefinitely.
REQ-016 SHALL in WRITE shift received bits LSB first into a byte register; on the 8th bit, the completed byte SHALL be written to mem[addr] on that same edge and addr SHALL increment modulo 2^ADDR_BITS.
REQ-017 SHALL discard a partially received write byte when spi_select rises.
REQ-018 SHALL drive spi_out to 0 in every state other than READ.
REQ-019 SHALL in IGNORE consume bits with no effect until deselect.
REQ-020 SHALL return to IDLE on any edge where spi_select is sampled high, regardless of state or spi_clk_enable, clearing the bit counters.
REQ-021 SHALL, for read-after-write to the same byte in a later transaction, return the written value; no hazard exists within one transaction.

Reset
REQ-022 SHALL on rst force state IDLE, clear all counters, the address register and the shift registers, and drive spi_out to 0.
REQ-023 SHALL NOT reset memory contents; memory is retained across rst and is undefined until written.
REQ-024 SHALL treat rst asserted mid-transaction as an abort; no partial byte is written.

Structure
REQ-025 SHALL place the command constants (READ 0x03, WRITE 0x02) and the state enumeration in a shared package spi_ram_pkg.
REQ-026 SHALL implement storage in one sub-module, spi_ram_array: a byte array with asynchronous read and synchronous write-enable, parameterized by ADDR_BITS.

Verification
REQ-027 Write test: select, cmd 0x02, addr 0x000010, data bytes 0xA5 0x3C (LSB first), deselect -> mem[0x10]=0xA5, mem[0x11]=0x3C.
REQ-028 Read test: after REQ-027, cmd 0x03 addr 0x000010 -> spi_out carries 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0, with the first bit in the slot right after the address.
REQ-029 Wrap test: write 0x11 to 0xFF and 0x22 to 0x00 in one write stream starting at 0x0000FF -> reading from 0xFF returns 0x11 then 0x22; an address of 0x1234FF aliases to 0xFF.
REQ-030 Gating test: insert random spi_clk_enable-low gaps in the REQ-028 read -> identical bit sequence, and spi_out is stable during gaps.
REQ-031 Abort test: write 0x02/0x000020 with 5 data bits then deselect; also command 0x9F -> mem[0x20] unchanged, spi_out stays 0, and the next transaction decodes normally.
REQ-032 Reset test: assert rst during READ bit 3 -> spi_out=0 immediately, state IDLE; previously written memory still reads back.
